// File: rtl/time_pkg.sv
// Shared constants, ring FSM encoding and BCD helpers for the time/alarm counters.
package time_pkg;
  localparam int MIN_W   = 7;
  localparam int HR_W    = 6;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  typedef enum logic {
    IDLE    = 1'b0,
    RINGING = 1'b1
  } ring_state_e;

  function automatic logic [6:0] bin_to_bcd(input int unsigned v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t[2:0], u};
  endfunction

  // One BCD step with wrap to zero at max_bin; hour values travel zero-extended.
  function automatic logic [6:0] bcd_step(input logic [6:0] v, input int unsigned max_bin);
    logic [6:0] r;
    if (v == bin_to_bcd(max_bin)) r = '0;
    else if (v[3:0] == 4'd9)      r = {v[6:4] + 3'd1, 4'd0};
    else                          r = {v[6:4], v[3:0] + 4'd1};
    return r;
  endfunction
endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping from MOD_TENS/MOD_UNITS to zero, with carry on wrap.
module bcd_mod_counter
  import time_pkg::*;
#(
  parameter int TENS_W    = 3,
  parameter int MOD_TENS  = 5,
  parameter int MOD_UNITS = 9
) (
  input  logic              ck,
  input  logic              reset,
  input  logic [TENS_W+3:0] rst_val,
  input  logic              inc,
  output logic [TENS_W+3:0] value,
  output logic              carry_out
);
  localparam int W = TENS_W + 4;
  localparam int unsigned MAX_BIN = MOD_TENS * 10 + MOD_UNITS;

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc) value_d = W'(bcd_step(7'(value_q), MAX_BIN));
  end

  always_ff @(posedge ck) begin
    if (reset) value_q <= rst_val;
    else       value_q <= value_d;
  end

  assign value     = value_q;
  assign carry_out = inc && (7'(value_q) == bin_to_bcd(MAX_BIN));
endmodule

// File: rtl/time_alarm_counters.sv
// Clock and alarm HH:MM BCD registers with increment pulses and a timed alarm ring.
module time_alarm_counters
  import time_pkg::*;
#(
  parameter int ALARM_RST_HR  = 7,
  parameter int ALARM_RST_MIN = 0,
  parameter int RING_MINUTES  = 1
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       up_clock60,
  input  logic       up_alarm60,
  input  logic       up_clock_hr,
  input  logic       up_alarm_hr,
  input  logic       alarm_en,
  input  logic       alarm_off,
  output logic [5:0] clk_hr,
  output logic [6:0] clk_min,
  output logic [5:0] alm_hr,
  output logic [6:0] alm_min,
  output logic       ring
);
  logic        clk_min_carry, alm_min_carry;
  logic        clk_hr_inc, alm_hr_inc;
  logic        clk_hr_carry_unused, alm_hr_carry_unused;
  logic [6:0]  clk_min_next;
  logic [5:0]  clk_hr_next;
  logic        ring_start;
  ring_state_e state_q, state_d;
  logic [3:0]  ring_cnt_q, ring_cnt_d;

  // A minute wrap and a direct hour pulse in the same cycle bump the hour once.
  assign clk_hr_inc = clk_min_carry | up_clock_hr;
  assign alm_hr_inc = alm_min_carry | up_alarm_hr;

  bcd_mod_counter #(.TENS_W(3), .MOD_TENS(5), .MOD_UNITS(9)) u_clk_min (
    .ck(ck), .reset(reset), .rst_val(7'd0), .inc(up_clock60),
    .value(clk_min), .carry_out(clk_min_carry));

  bcd_mod_counter #(.TENS_W(2), .MOD_TENS(2), .MOD_UNITS(3)) u_clk_hr (
    .ck(ck), .reset(reset), .rst_val(6'd0), .inc(clk_hr_inc),
    .value(clk_hr), .carry_out(clk_hr_carry_unused));

  bcd_mod_counter #(.TENS_W(3), .MOD_TENS(5), .MOD_UNITS(9)) u_alm_min (
    .ck(ck), .reset(reset), .rst_val(bin_to_bcd(ALARM_RST_MIN)), .inc(up_alarm60),
    .value(alm_min), .carry_out(alm_min_carry));

  bcd_mod_counter #(.TENS_W(2), .MOD_TENS(2), .MOD_UNITS(3)) u_alm_hr (
    .ck(ck), .reset(reset), .rst_val(6'(bin_to_bcd(ALARM_RST_HR))), .inc(alm_hr_inc),
    .value(alm_hr), .carry_out(alm_hr_carry_unused));

  // The start compare uses the upcoming clock against the alarm as it is now,
  // so moving the alarm onto the current time never starts the ring.
  always_comb begin
    clk_min_next = up_clock60 ? bcd_step(clk_min, MIN_MAX) : clk_min;
    clk_hr_next  = clk_hr_inc ? 6'(bcd_step(7'(clk_hr), HR_MAX)) : clk_hr;
    ring_start   = (up_clock60 | up_clock_hr) & alarm_en &
                   (clk_hr_next == alm_hr) & (clk_min_next == alm_min);
  end

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    case (state_q)
      IDLE: begin
        if (ring_start && !alarm_off) begin
          state_d    = RINGING;
          ring_cnt_d = 4'(RING_MINUTES);
        end
      end
      RINGING: begin
        if (alarm_off || !alarm_en) begin
          state_d    = IDLE;
          ring_cnt_d = '0;
        end else if (up_clock60) begin
          if (ring_cnt_q == 4'd1) begin
            state_d    = IDLE;
            ring_cnt_d = '0;
          end else begin
            ring_cnt_d = ring_cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        ring_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  assign ring = (state_q == RINGING);
endmodule

// File: tb/tb_time_alarm_counters.sv
// Directed and randomized bench for time_alarm_counters against a minutes-of-day model.
module tb_time_alarm_counters;
  localparam int RING_MIN = 1;

  logic       ck = 1'b0;
  logic       reset = 1'b1;
  logic       up_clock60 = 1'b0, up_alarm60 = 1'b0, up_clock_hr = 1'b0, up_alarm_hr = 1'b0;
  logic       alarm_en = 1'b0, alarm_off = 1'b0;
  logic [5:0] clk_hr, alm_hr;
  logic [6:0] clk_min, alm_min;
  logic       ring;

  int checks = 0;
  int failures = 0;

  // reference model state: plain integers
  int m_ch, m_cm, m_ah, m_am, m_cnt;
  bit m_ring;

  time_alarm_counters #(.ALARM_RST_HR(7), .ALARM_RST_MIN(0), .RING_MINUTES(RING_MIN)) dut (
    .ck(ck), .reset(reset),
    .up_clock60(up_clock60), .up_alarm60(up_alarm60),
    .up_clock_hr(up_clock_hr), .up_alarm_hr(up_alarm_hr),
    .alarm_en(alarm_en), .alarm_off(alarm_off),
    .clk_hr(clk_hr), .clk_min(clk_min), .alm_hr(alm_hr), .alm_min(alm_min),
    .ring(ring));

  always #5 ck = ~ck;

  function automatic logic [6:0] to_bcd(input int v);
    logic [6:0] r;
    r = 7'((v / 10) * 16 + (v % 10));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".clk_hr"},  7'(clk_hr),  to_bcd(m_ch));
    chk({tag, ".clk_min"}, clk_min,     to_bcd(m_cm));
    chk({tag, ".alm_hr"},  7'(alm_hr),  to_bcd(m_ah));
    chk({tag, ".alm_min"}, alm_min,     to_bcd(m_am));
    chk({tag, ".ring"},    7'(ring),    7'(m_ring));
  endtask

  task automatic model_step(input bit c60, a60, chr, ahr, en, off);
    int nch, ncm, nah, nam;
    bit hinc, ahinc, start;
    ncm = m_cm; nch = m_ch; nam = m_am; nah = m_ah;
    hinc = chr; ahinc = ahr;
    if (c60) begin ncm = (m_cm + 1) % 60; if (m_cm == 59) hinc = 1; end
    if (hinc) nch = (m_ch + 1) % 24;
    if (a60) begin nam = (m_am + 1) % 60; if (m_am == 59) ahinc = 1; end
    if (ahinc) nah = (m_ah + 1) % 24;
    start = (c60 || chr) && en && (nch * 60 + ncm == m_ah * 60 + m_am);
    if (!m_ring) begin
      if (start && !off) begin m_ring = 1; m_cnt = RING_MIN; end
    end else if (off || !en) begin
      m_ring = 0; m_cnt = 0;
    end else if (c60) begin
      m_cnt--;
      if (m_cnt == 0) m_ring = 0;
    end
    m_ch = nch; m_cm = ncm; m_ah = nah; m_am = nam;
  endtask

  task automatic cycle(input bit c60, a60, chr, ahr, en, off);
    @(negedge ck);
    reset = 0; up_clock60 = c60; up_alarm60 = a60; up_clock_hr = chr; up_alarm_hr = ahr;
    alarm_en = en; alarm_off = off;
    model_step(c60, a60, chr, ahr, en, off);
    @(posedge ck); #1;
    check_all("step");
  endtask

  task automatic do_reset();
    @(negedge ck);
    reset = 1; up_clock60 = 0; up_alarm60 = 0; up_clock_hr = 0; up_alarm_hr = 0;
    alarm_en = 0; alarm_off = 0;
    m_ch = 0; m_cm = 0; m_ah = 7; m_am = 0; m_ring = 0; m_cnt = 0;
    @(posedge ck); #1;
    check_all("reset");
  endtask

  task automatic set_clock(input int h, input int m);
    while (m_cm != m) cycle(1, 0, 0, 0, 0, 0);
    while (m_ch != h) cycle(0, 0, 1, 0, 0, 0);
  endtask

  task automatic set_alarm(input int h, input int m);
    while (m_am != m) cycle(0, 1, 0, 0, 0, 0);
    while (m_ah != h) cycle(0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    int t, k;
    do_reset();
    do_reset();
    chk("rst_clk_hr", 7'(clk_hr), 7'h00);
    chk("rst_alm_hr", 7'(alm_hr), 7'h07);
    chk("rst_ring", 7'(ring), 7'h0);

    set_clock(23, 59);
    cycle(1, 0, 0, 0, 0, 0);
    chk("wrap_day_hr", 7'(clk_hr), 7'h00);
    chk("wrap_day_min", clk_min, 7'h00);

    set_clock(9, 59);
    cycle(1, 0, 0, 0, 0, 0);
    chk("tens_hr", 7'(clk_hr), 7'h10);
    chk("tens_min", clk_min, 7'h00);

    set_clock(12, 59);
    cycle(1, 0, 1, 0, 0, 0);
    chk("or_hr", 7'(clk_hr), 7'h13);
    chk("or_min", clk_min, 7'h00);

    set_alarm(19, 59);
    cycle(0, 1, 0, 0, 0, 0);
    chk("alm_carry_hr", 7'(alm_hr), 7'h20);
    chk("alm_carry_min", alm_min, 7'h00);

    do_reset();
    set_clock(6, 59);
    cycle(1, 0, 0, 0, 1, 0);
    chk("ring_start", 7'(ring), 7'h1);
    chk("ring_start_hr", 7'(clk_hr), 7'h07);
    cycle(1, 0, 0, 0, 1, 0);
    chk("ring_expire", 7'(ring), 7'h0);
    chk("ring_expire_min", clk_min, 7'h01);

    set_clock(6, 59);
    cycle(1, 0, 0, 0, 1, 0);
    chk("ring_start2", 7'(ring), 7'h1);
    cycle(0, 0, 0, 0, 1, 1);
    chk("ring_off", 7'(ring), 7'h0);
    cycle(0, 0, 0, 0, 1, 1);

    set_clock(6, 59);
    cycle(1, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("ring_en_drop", 7'(ring), 7'h0);

    set_clock(6, 0);
    cycle(0, 0, 1, 0, 1, 0);
    chk("ring_by_hr", 7'(ring), 7'h1);
    do_reset();
    chk("mid_ring_reset", 7'(ring), 7'h0);
    chk("mid_ring_reset_alm", 7'(alm_hr), 7'h07);

    set_clock(6, 59);
    cycle(1, 0, 0, 0, 1, 1);
    chk("off_beats_start", 7'(ring), 7'h0);

    set_clock(7, 0);
    set_alarm(6, 59);
    cycle(0, 1, 0, 0, 1, 0);
    chk("alarm_onto_time", 7'(ring), 7'h0);
    cycle(0, 0, 0, 0, 1, 0);

    set_clock(6, 59);
    cycle(1, 0, 0, 0, 0, 0);
    chk("disarmed", 7'(ring), 7'h0);

    for (int r = 0; r < 8; r++) begin
      set_alarm($urandom_range(0, 23), $urandom_range(0, 59));
      k = $urandom_range(1, 5);
      t = (m_ah * 60 + m_am - k + 1440) % 1440;
      set_clock(t / 60, t % 60);
      for (int i = 0; i < 40; i++)
        cycle($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
              $urandom_range(0, 9) != 0, $urandom_range(0, 14) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/time_alarm_counters.md
Name: time_alarm_counters

Overview:
Downstream consumer of the minute-button controller. Holds the BCD time-of-day registers (clock HH:MM) and the alarm-setting registers (alarm HH:MM). Applies single-cycle increment pulses from the controller and from the 1-minute timebase, and raises and holds the alarm ring output. Drives the display mux and the buzzer stage.

Parameters:
ALARM_RST_HR, 7, alarm hour loaded on reset (0..23, binary; converted to BCD internally)
ALARM_RST_MIN, 0, alarm minute loaded on reset (0..59)
RING_MINUTES, 1, number of clock-minute ticks the ring stays active if not silenced (1..15)

Ports:
ck  in  1  system clock
reset  in  1  synchronous, active-high reset
up_clock60  in  1  one-cycle pulse: clock minute +1 (from timebase or controller)
up_alarm60  in  1  one-cycle pulse: alarm minute +1
up_clock_hr  in  1  one-cycle pulse: clock hour +1, minutes untouched
up_alarm_hr  in  1  one-cycle pulse: alarm hour +1, minutes untouched
alarm_en  in  1  level: alarm armed
alarm_off  in  1  one-cycle pulse: silence ring
clk_hr  out  6  clock hours BCD {tens[5:4], units[3:0]}, 00..23
clk_min  out  7  clock minutes BCD {tens[6:4], units[3:0]}, 00..59
alm_hr  out  6  alarm hours BCD
alm_min  out  7  alarm minutes BCD
ring  out  1  registered; alarm sounding

Behaviour:
- All state updates on posedge ck. Reset: clk_hr=00, clk_min=00, alm_hr=ALARM_RST_HR, alm_min=ALARM_RST_MIN, ring=0, ring counter=0. Reset overrides every other input.
- Latency: each register updates on the edge that samples the pulse; the new value is visible the next cycle.
- Minute counters: BCD units 0..9. Tens carry at 9. 59 -> 00 with carry-out.
- Hour counters: 23 -> 00. Units 9 -> 0 with tens+1. Tens/units pair 2/3 -> 0/0.
- Clock: clock minute carry-out increments the clock hour. up_clock_hr also increments the hour. If the carry and up_clock_hr occur in the same cycle, the hour is incremented once (the two are ORed).
- Alarm: alarm minute 59 -> 00 also carries into the alarm hour. The same OR rule applies with up_alarm_hr.
- Clock and alarm paths are independent. Simultaneous pulses on both paths both apply.
- Ring start: on a cycle with any clock increment (up_clock60 or up_clock_hr), compute the next clock value. If alarm_en=1 and next clock == current alarm (with any same-cycle alarm increment excluded, i.e. compare against the pre-update alarm), then ring <= 1 and ring counter <= RING_MINUTES on the same edge as the time update.
- Setting the alarm equal to the current time never starts the ring.
- Ring FSM states:
  - IDLE (ring=0)
  - RINGING (ring=1)
- IDLE -> RINGING on the start condition.
- RINGING -> IDLE when any of the following hold:
  - alarm_off=1
  - alarm_en=0
  - ring counter reaches 0. The counter decrements on each up_clock60 pulse while ringing; the transition occurs on the edge where a decrement would go 1 -> 0.
- Priority in RINGING: alarm_off / !alarm_en over counter expiry over restart. A start condition while RINGING does not reload the counter.
- alarm_off in IDLE has no effect. alarm_off coincident with a start condition wins, so ring stays 0.
- Counter width: 4 bits.

Decomposition:
- Shared package (time_pkg): BCD widths; constants MIN_MAX=59, HR_MAX=23; ring FSM state encoding (IDLE=0, RINGING=1).
- Sub-module bcd_mod_counter: parameters TENS_W and MOD_TENS/MOD_UNITS; ports ck, reset, rst_val, inc, value, carry_out. Instantiated four times (clock min/hr, alarm min/hr).
- Top level holds the hour-increment OR logic, next-value compare and ring FSM.

Test Plan:
- Reset -> clk 00:00, alarm 07:00, ring=0. Reset asserted mid-ring at clock 07:00 -> ring=0 and registers reload the next cycle.
- Clock set to 23:59, one up_clock60 pulse -> 00:00 one cycle later. Clock at 09:59 + pulse -> 10:00.
- Clock 12:59, up_clock60 and up_clock_hr in the same cycle -> 13:00 (not 14:00). Alarm 19:59 + up_alarm60 -> 20:00.
- Alarm 07:00, alarm_en=1, clock 06:59, up_clock60 -> ring=1 on the same edge as clock 07:00. With RING_MINUTES=1, next up_clock60 -> ring=0 and clock 07:01.
- Ringing, alarm_off pulse -> ring=0 next cycle. Ringing, alarm_en dropped -> ring=0 next cycle.
- Clock 07:00, alarm at 06:59 stepped via up_alarm60 to 07:00 -> ring stays 0. alarm_en=0 with clock 06:59 -> 07:00 -> ring stays 0.
